// File: rtl/serial_add_sequencer_if.sv
// Operand/result handshake bundle for serial_add_sequencer.
// Optional sub input is present only when SERIAL_ADD_SUB_EN is defined.
interface serial_add_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub;
`endif

  modport master (
`ifdef SERIAL_ADD_SUB_EN
    output sub,
`endif
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
`ifdef SERIAL_ADD_SUB_EN
    input  sub,
`endif
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );
endinterface

// File: rtl/serial_add_sequencer.sv
// Bit-serial WIDTH-bit adder: one full-adder cell reused LSB first, one bit per clock.
// Define SERIAL_ADD_SUB_EN to add a sub input (a - b via inverted b and carry-in 1).
module serial_add_sequencer #(
  parameter int WIDTH = 8
) (
  input logic                  clk,
  input logic                  rst,
  serial_add_sequencer_if.slave bus
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_r;
  logic             c;
  logic [CNT_W-1:0] cnt;

  logic half_p;
  logic s_bit;
  logic c_next;
  logic load_sub;

  // Two half adders plus the carry flop form the single shared cell.
  always_comb begin
    half_p = a_sr[0] ^ b_sr[0];
    s_bit  = half_p ^ c;
    c_next = (a_sr[0] & b_sr[0]) | (c & half_p);
  end

`ifdef SERIAL_ADD_SUB_EN
  assign load_sub = bus.sub;
`else
  assign load_sub = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      sum_r <= '0;
      c     <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_sr  <= bus.a;
            b_sr  <= load_sub ? ~bus.b : bus.b;
            c     <= load_sub;
            cnt   <= '0;
            sum_r <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          sum_r <= {s_bit, sum_r[WIDTH-1:1]};
          c     <= c_next;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) state <= DONE;
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The carry flop doubles as cout: it holds the final carry once RUN ends.
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state == RUN);
  assign bus.sum       = sum_r;
  assign bus.cout      = c;
endmodule
